operand_scoreboard: RTL and testbench
=====================================

# operand_scoreboard

Register-operand hazard scoreboard placed between the decode stage and issue. It tracks how many writes are in flight to each of the 32 integer registers. An instruction is allowed to read its rs1/rs2 operands from the register file only when no older write to those registers is outstanding. It also bounds in-flight writes per destination and keeps a saturating stall counter for performance monitoring.

## Interface
Parameters:
- PENDING_WIDTH, 2, width of each per-register in-flight write counter; maximum in-flight writes per register is 2^PENDING_WIDTH-1
- STALL_COUNT_WIDTH, 32, width of the stall performance counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- issue_valid  input  1  decode presents an instruction
- issue_ready  output  1  scoreboard accepts it this cycle (combinational)
- issue_rs1_index  input  5  source register 1 index
- issue_rs1_used  input  1  instruction reads rs1
- issue_rs2_index  input  5  source register 2 index
- issue_rs2_used  input  1  instruction reads rs2
- issue_rd_index  input  5  destination index
- issue_rd_write  input  1  instruction writes rd
- wb_valid  input  1  a register write retires this cycle
- wb_rd_index  input  5  index of the retiring write
- flush  input  1  pipeline flush: discard all outstanding writes
- reg_busy  output  32  bit i = counter[i] != 0 (registered view)
- wb_underflow  output  1  sticky error: writeback retired to a register with zero count
- stall_count  output  STALL_COUNT_WIDTH  cycles with issue_valid && !issue_ready

## Operation
- State: counter[1..31], each PENDING_WIDTH bits. x0 has no counter. Reads of x0 never hazard. Writes to x0 never count.
- wb_hit(r) = wb_valid && wb_rd_index == r && r != 0. The register file is write-through, so a same-cycle writeback resolves a hazard.
- eff(r) = counter[r] - (wb_hit(r) && counter[r] != 0).
- RAW hazard: (rs1_used && rs1 != 0 && eff(rs1) != 0) || the same condition for rs2.
- WAW limit: rd_write && rd != 0 && counter[rd] == max && !wb_hit(rd).
- issue_ready = !rst && !flush && !RAW && !WAW_limit. issue_ready does not depend on issue_valid.
- fire = issue_valid && issue_ready.
- Counter update per register r, with inc = fire && rd_write && rd == r:
  - inc && !wb_hit: +1
  - wb_hit && !inc: -1 if nonzero
  - both: unchanged
- Writeback to a zero counter: counter stays 0 and wb_underflow sets. wb_underflow clears only on rst.
- flush: all counters go to 0 at the next edge, and any same-cycle writeback or issue is ignored for counter purposes. The flush-cycle underflow check is still performed.
- reg_busy[0] is always 0. reg_busy reflects counters after the edge.
- stall_count increments when issue_valid && !issue_ready (this includes flush cycles). It saturates at all-ones and clears only on rst.

## Timing
- Reset: counters 0, reg_busy 0, wb_underflow 0, stall_count 0. issue_ready is 0 while rst is high.
- Reset in mid-operation discards all in-flight tracking. Writebacks that arrive after reset to zero counters set wb_underflow, so upstream must squash them.
- An issue fire at edge N makes a dependent reader at cycle N+1 see the hazard (zero-bubble detection).
- A writeback at cycle M releases a reader presented in cycle M (same-cycle resolution).
- A dependent reader issued back-to-back after a producer stalls until that producer's writeback cycle, inclusive release.
- Multiple writers to the same rd: the reader waits until all of them have retired (counter reaches 0, or reaches 1 with wb_hit).
- Counter width: an increment never overflows, because the WAW limit blocks it. A decrement never underflows.

## Test plan
- Reset, then issue rd=x5 write; next cycle issue reading rs1=x5 -> issue_ready=0, reg_busy[5]=1, stall_count increments. Assert wb x5 -> issue_ready=1 that same cycle; reg_busy[5]=0 the next cycle.
- Issue three writes to x7 (PENDING_WIDTH=2) -> counter 3; fourth write to x7 -> issue_ready=0. Same cycle with wb x7 -> accepted, counter stays 3.
- rs1=x0, rs2=x0, rd=x0 with all other registers busy -> issue_ready=1 and reg_busy[0] stays 0. wb to x0 -> no underflow.
- Simultaneous issue rd=x3 and wb x3 with counter 1 -> counter remains 1, reg_busy[3]=1.
- x4 and x9 busy, flush=1 with issue_valid -> issue_ready=0; next cycle reg_busy=0. A later wb x4 -> wb_underflow=1, stays set until rst.
- Preload stall_count to near saturation by holding a hazard for 2^STALL_COUNT_WIDTH cycles (use STALL_COUNT_WIDTH=4 in the bench) -> stall_count holds 15 and does not wrap.

Source files
------------

// File: rtl/operand_scoreboard.sv
// Register-operand hazard scoreboard: per-register in-flight write counters
// gate issue on RAW hazards and bound outstanding writes per destination.
module operand_scoreboard #(
  parameter int PENDING_WIDTH     = 2,
  parameter int STALL_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [4:0]                   issue_rs1_index,
  input  logic                         issue_rs1_used,
  input  logic [4:0]                   issue_rs2_index,
  input  logic                         issue_rs2_used,
  input  logic [4:0]                   issue_rd_index,
  input  logic                         issue_rd_write,
  input  logic                         wb_valid,
  input  logic [4:0]                   wb_rd_index,
  input  logic                         flush,
  output logic [31:0]                  reg_busy,
  output logic                         wb_underflow,
  output logic [STALL_COUNT_WIDTH-1:0] stall_count
);

  localparam int NREGS = 32;

  typedef logic [PENDING_WIDTH-1:0] cnt_t;

  cnt_t             cnt      [NREGS];
  cnt_t             cnt_next [NREGS];
  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] inc;

  cnt_t rs1_cnt;
  cnt_t rs2_cnt;
  cnt_t rd_cnt;
  cnt_t wb_cnt;

  logic raw_rs1;
  logic raw_rs2;
  logic waw_limit;
  logic fire;
  logic underflow_now;
  logic stall_now;

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      wb_hit[r] = wb_valid && (wb_rd_index == 5'(r)) && (r != 0);
    end
  end

  always_comb begin
    rs1_cnt = cnt[issue_rs1_index];
    rs2_cnt = cnt[issue_rs2_index];
    rd_cnt  = cnt[issue_rd_index];
    wb_cnt  = cnt[wb_rd_index];
  end

  // Write-through register file: a writeback retiring the last outstanding
  // write releases a reader in the same cycle.
  always_comb begin
    raw_rs1 = issue_rs1_used && (issue_rs1_index != '0) && (rs1_cnt != '0) &&
              !(wb_hit[issue_rs1_index] && (rs1_cnt == cnt_t'(1)));
    raw_rs2 = issue_rs2_used && (issue_rs2_index != '0) && (rs2_cnt != '0) &&
              !(wb_hit[issue_rs2_index] && (rs2_cnt == cnt_t'(1)));
    waw_limit = issue_rd_write && (issue_rd_index != '0) && (rd_cnt == '1) &&
                !wb_hit[issue_rd_index];
  end

  always_comb begin
    issue_ready   = !rst && !flush && !raw_rs1 && !raw_rs2 && !waw_limit;
    fire          = issue_valid && issue_ready;
    stall_now     = issue_valid && !issue_ready;
    underflow_now = wb_valid && (wb_rd_index != '0) && (wb_cnt == '0);
  end

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      inc[r] = fire && issue_rd_write && (issue_rd_index == 5'(r)) && (r != 0);
    end
  end

  // A simultaneous issue and writeback to the same register cancel out.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_next[r] = cnt[r];
      if (r == 0 || flush) begin
        cnt_next[r] = '0;
      end else if (inc[r] && !wb_hit[r]) begin
        cnt_next[r] = cnt[r] + cnt_t'(1);
      end else if (wb_hit[r] && !inc[r] && (cnt[r] != '0)) begin
        cnt_next[r] = cnt[r] - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt[r] <= '0;
      end
      wb_underflow <= 1'b0;
      stall_count  <= '0;
    end else begin
      cnt <= cnt_next;
      if (underflow_now) begin
        wb_underflow <= 1'b1;
      end
      if (stall_now && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      reg_busy[r] = (cnt[r] != '0);
    end
  end

endmodule

// File: tb/tb_operand_scoreboard.sv
// Self-checking bench for operand_scoreboard: directed scenarios with literal
// expectations, then randomized traffic checked against an integer model.
module tb_operand_scoreboard;

  localparam int PW   = 2;
  localparam int SCW  = 4;
  localparam int MAXC = (1 << PW) - 1;
  localparam int MAXS = (1 << SCW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           issue_valid;
  logic           issue_ready;
  logic [4:0]     issue_rs1_index;
  logic           issue_rs1_used;
  logic [4:0]     issue_rs2_index;
  logic           issue_rs2_used;
  logic [4:0]     issue_rd_index;
  logic           issue_rd_write;
  logic           wb_valid;
  logic [4:0]     wb_rd_index;
  logic           flush;
  logic [31:0]    reg_busy;
  logic           wb_underflow;
  logic [SCW-1:0] stall_count;

  operand_scoreboard #(.PENDING_WIDTH(PW), .STALL_COUNT_WIDTH(SCW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1_index(issue_rs1_index), .issue_rs1_used(issue_rs1_used),
    .issue_rs2_index(issue_rs2_index), .issue_rs2_used(issue_rs2_used),
    .issue_rd_index(issue_rd_index), .issue_rd_write(issue_rd_write),
    .wb_valid(wb_valid), .wb_rd_index(wb_rd_index), .flush(flush),
    .reg_busy(reg_busy), .wb_underflow(wb_underflow), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer count of in-flight writes per register.
  int m_cnt [32];
  bit m_uf;
  int m_stall;

  function automatic bit m_hit(input int r);
    return wb_valid && (int'(wb_rd_index) == r) && (r != 0);
  endfunction

  function automatic int m_eff(input int r);
    return m_cnt[r] - ((m_hit(r) && m_cnt[r] != 0) ? 1 : 0);
  endfunction

  function automatic bit m_ready();
    bit raw;
    bit waw;
    int a;
    int b;
    int d;
    a = int'(issue_rs1_index);
    b = int'(issue_rs2_index);
    d = int'(issue_rd_index);
    raw = (issue_rs1_used && a != 0 && m_eff(a) != 0) ||
          (issue_rs2_used && b != 0 && m_eff(b) != 0);
    waw = issue_rd_write && d != 0 && m_cnt[d] == MAXC && !m_hit(d);
    return !rst && !flush && !raw && !waw;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] v;
    v = '0;
    for (int r = 1; r < 32; r++) v[r] = (m_cnt[r] != 0);
    return v;
  endfunction

  always @(posedge clk) begin
    bit f;
    bit incr;
    bit h;
    if (rst) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_uf = 0;
      m_stall = 0;
    end else begin
      f = issue_valid && m_ready();
      if (issue_valid && !m_ready() && m_stall < MAXS) m_stall++;
      if (wb_valid && wb_rd_index != 0 && m_cnt[wb_rd_index] == 0) m_uf = 1;
      if (flush) begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      end else begin
        for (int r = 1; r < 32; r++) begin
          incr = f && issue_rd_write && int'(issue_rd_index) == r;
          h = m_hit(r);
          if (incr && !h) m_cnt[r]++;
          else if (h && !incr && m_cnt[r] > 0) m_cnt[r]--;
        end
      end
    end
  end

  // Inputs change at posedge+1 (and +3 in directed steps); compare mid-low phase.
  always @(negedge clk) begin
    chk("ready", 32'(issue_ready), 32'(m_ready()));
    chk("reg_busy", reg_busy, m_busy());
    chk("underflow", 32'(wb_underflow), 32'(m_uf));
    chk("stall_count", 32'(stall_count), 32'(m_stall));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1_index = 0; issue_rs1_used = 0;
    issue_rs2_index = 0; issue_rs2_used = 0; issue_rd_index = 0;
    issue_rd_write = 0; wb_valid = 0; wb_rd_index = 0; flush = 0;
  endtask

  task automatic iss(input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit w);
    issue_valid = 1;
    issue_rs1_index = 5'(rs1); issue_rs1_used = u1;
    issue_rs2_index = 5'(rs2); issue_rs2_used = u2;
    issue_rd_index  = 5'(rd);  issue_rd_write = w;
  endtask

  task automatic wb(input int r);
    wb_valid = 1;
    wb_rd_index = 5'(r);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc(); #2;
    chk("ready_in_rst", 32'(issue_ready), 32'd0);
    cyc();
    rst = 0;
  endtask

  initial begin
    idle();
    do_reset();
    #2;
    chk("rst_busy", reg_busy, 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    chk("rst_uf", 32'(wb_underflow), 32'd0);

    // Producer then dependent reader, released by same-cycle writeback.
    cyc(); iss(0, 0, 0, 0, 5, 1); #2;
    chk("t1_prod_ready", 32'(issue_ready), 32'd1);
    cyc(); idle(); iss(5, 1, 0, 0, 0, 0); #2;
    chk("t1_raw_ready", 32'(issue_ready), 32'd0);
    chk("t1_busy5", 32'(reg_busy[5]), 32'd1);
    cyc(); #2;
    chk("t1_stall", 32'(stall_count), 32'd1);
    wb(5); #1;
    chk("t1_wb_release", 32'(issue_ready), 32'd1);
    cyc(); idle(); #2;
    chk("t1_busy5_clr", 32'(reg_busy[5]), 32'd0);

    // WAW limit on x7.
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); iss(0, 0, 0, 0, 7, 1);
    end
    cyc(); #2;
    chk("t2_waw_block", 32'(issue_ready), 32'd0);
    wb(7); #1;
    chk("t2_waw_wb_ok", 32'(issue_ready), 32'd1);
    cyc(); #2;
    wb_valid = 0;
    #0.1;
    chk("t2_still_full", 32'(issue_ready), 32'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); wb(7);
    end
    cyc(); idle(); #2;
    chk("t2_drained", 32'(reg_busy[7]), 32'd0);
    chk("t2_stall", 32'(stall_count), 32'd1);

    // Fill x1..x31, then x0-only traffic.
    for (int r = 1; r < 32; r++) begin
      cyc(); idle(); iss(0, 0, 0, 0, r, 1);
    end
    cyc(); idle(); iss(0, 1, 0, 1, 0, 1); #2;
    chk("t3_x0_ready", 32'(issue_ready), 32'd1);
    cyc(); idle(); wb(0); #2;
    chk("t3_busy_all", reg_busy, 32'hFFFF_FFFE);
    cyc(); idle(); #2;
    chk("t3_x0_no_uf", 32'(wb_underflow), 32'd0);

    // Simultaneous issue and writeback to x3 with count 1.
    cyc(); iss(0, 0, 0, 0, 3, 1); wb(3); #2;
    chk("t4_ready", 32'(issue_ready), 32'd1);
    cyc(); idle(); #2;
    chk("t4_busy3", 32'(reg_busy[3]), 32'd1);
    wb(3);
    cyc(); idle(); #2;
    chk("t4_busy3_clr", 32'(reg_busy[3]), 32'd0);

    // Flush with x4/x9 busy, then late writeback underflows.
    cyc(); iss(0, 0, 0, 0, 12, 1); flush = 1; #2;
    chk("t5_flush_ready", 32'(issue_ready), 32'd0);
    cyc(); idle(); #2;
    chk("t5_busy_clr", reg_busy, 32'd0);
    chk("t5_stall", 32'(stall_count), 32'd2);
    wb(4);
    cyc(); idle(); #2;
    chk("t5_uf_set", 32'(wb_underflow), 32'd1);
    repeat (3) cyc();
    #2;
    chk("t5_uf_sticky", 32'(wb_underflow), 32'd1);
    do_reset();
    #2;
    chk("t5_uf_rst", 32'(wb_underflow), 32'd0);

    // Stall counter saturation.
    cyc(); iss(0, 0, 0, 0, 5, 1);
    cyc(); idle(); iss(5, 1, 5, 1, 0, 0);
    repeat (20) cyc();
    #2;
    chk("t6_stall_sat", 32'(stall_count), 32'd15);
    cyc(); idle(); wb(5);
    cyc(); idle();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 4000; n++) begin
      int r;
      cyc();
      idle();
      if ($urandom_range(0, 299) == 0) begin
        rst = 1;
      end else begin
        rst = 0;
        if ($urandom_range(0, 3) != 0)
          iss($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
              $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0));
        r = $urandom_range(0, 7);
        if (m_cnt[r] != 0 ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0))
          wb(r);
        if ($urandom_range(0, 99) == 0) flush = 1;
      end
    end
    cyc(); idle(); rst = 0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
